// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
//   UART receiver with built-in baud timing. Frame: 1 start bit, DATA_BITS
//   data bits (LSB first), optional parity bit, STOP_BITS stop bits.
//   The received word is offered on a valid/ready handshake together with
//   its parity/framing flags. A frame that completes while the previous word
//   is still unaccepted is dropped, and the sticky overrun flag is raised.
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   uart_rx    serial input (idle high)
//   rx_data    received word, held while rx_valid
//   rx_valid   word available
//   rx_ready   consumer accepts the word when high together with rx_valid
//   parity_err parity mismatch on the held word (always 0 when PARITY = 0)
//   frame_err  a stop bit of the held word was sampled low
//   overrun    sticky; a frame arrived while the held word was unaccepted
//   busy       receiver is inside a frame (not IDLE)
// ---------------------------------------------------------------------------
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == 1);
  localparam logic          HAS_PAR   = (PARITY != 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // ---- input synchroniser ------------------------------------------------
  logic [1:0] r_sync;
  logic       r_rxs_d;
  logic       w_rxs;

  assign w_rxs = r_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[0], uart_rx};
      r_rxs_d <= w_rxs;
    end
  end

  // ---- frame FSM -----------------------------------------------------------
  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr_f;   // parity result of the frame in flight
  logic                 r_ferr_f;   // any stop bit so far sampled low

  logic w_tick_half;
  logic w_tick;
  logic w_par_bad;
  logic w_done;
  logic w_ferr_fin;

  assign w_tick_half = (r_cnt == CNT_HALF);
  assign w_tick      = (r_cnt == CNT_FULL);
  // Even parity: data ^ parity bit must be 0; odd parity: must be 1.
  assign w_par_bad   = ((^r_shift) ^ w_rxs) != ODD_PAR;
  // Final stop sample: completion happens on this same clock edge, so the
  // framing result has to include the bit being sampled right now.
  assign w_done      = (r_state == S_STOP) && w_tick && (r_idx == LAST_STOP);
  assign w_ferr_fin  = r_ferr_f | ~w_rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_perr_f <= 1'b0;
      r_ferr_f <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_rxs_d && !w_rxs) begin
            r_cnt   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick_half) begin
            r_cnt <= '0;
            if (!w_rxs) begin
              r_state  <= S_DATA;
              r_idx    <= '0;
              r_perr_f <= 1'b0;
              r_ferr_f <= 1'b0;
            end else begin
              // line back high at mid start bit: glitch, drop silently
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            if (r_idx == LAST_DATA) begin
              r_idx   <= '0;
              r_state <= HAS_PAR ? S_PAR : S_STOP;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_PAR: begin
          if (w_tick) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_perr_f <= w_par_bad;
            r_state  <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (!w_rxs) r_ferr_f <= 1'b1;
            if (r_idx == LAST_STOP) begin
              r_idx   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---- output holding register and handshake -------------------------------
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_overrun;
  logic                 w_hs;

  assign w_hs = r_valid & rx_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_hs) r_overrun <= 1'b0;
      if (w_done) begin
        // A handshake on the completion cycle frees the slot for the new word.
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_perr  <= r_perr_f;
          r_ferr  <= w_ferr_fin;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver with integrated baud timing, configurable frame format (5–9 data bits, none/odd/even parity, 1 or 2 stop bits), and a valid/ready output handshake with error and overrun reporting. It sits between the board's serial RX pin and the CPU's memory-mapped peripheral bus. The bus consumes one received word per handshake. No external baud-tick source is required.

## Interface
Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); legal ≥ 4
- DATA_BITS, 8, data bits per frame; legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, stop bits checked; legal 1 or 2

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- uart_rx  in  1  serial input, idle high, LSB first
- rx_data  out  DATA_BITS  received word, held while rx_valid
- rx_valid  out  1  word available
- rx_ready  in  1  consumer accepts word when high with rx_valid
- parity_err  out  1  parity mismatch on the held word (0 if PARITY = 0)
- frame_err  out  1  a stop bit sampled low on the held word
- overrun  out  1  sticky; a frame completed while the previous word was unaccepted
- busy  out  1  receiver not in IDLE

## Operation
- Input synchroniser: two flops, reset to 1. rxs is the second flop. rxs_d is rxs delayed one cycle.
- Bit counter cnt has width clog2(CLKS_PER_BIT). Bit index idx counts up to 9.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: when rxs_d = 1 and rxs = 0, clear cnt and go to START.
  - START: when cnt = CLKS_PER_BIT/2 − 1, sample rxs. If 0, go to DATA with cnt = 0 and idx = 0. If 1, it is a glitch: return to IDLE with no output effect.
  - DATA: when cnt = CLKS_PER_BIT − 1, shift rxs into the MSB of the shift register (right-shift, LSB-first) and increment idx. After DATA_BITS samples, go to PAR if PARITY ≠ 0, else STOP.
  - PAR: sample once. Error = (XOR of data bits XOR sampled bit) ≠ (PARITY == 1).
  - STOP: sample STOP_BITS times at CLKS_PER_BIT spacing. Any 0 sample sets the frame error.
  - After the final STOP sample, complete the frame and go to IDLE. A new start edge is accepted from the next cycle.
- Frame completion rules:
  - If rx_valid = 0, or rx_valid & rx_ready in the same cycle: load rx_data, parity_err and frame_err, and set rx_valid = 1.
  - Otherwise: discard the new frame, keep the held word and flags, and set overrun = 1.
- Handshake rules:
  - rx_valid & rx_ready with no completion in that cycle: rx_valid → 0.
  - overrun clears on any cycle with rx_valid & rx_ready.
- Frames with frame_err (including break, all zeros) are still delivered.
- rx_data, parity_err and frame_err are don't-care when rx_valid = 0, but hold their last value.

## Timing
- Reset values: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0. FSM = IDLE. Synchroniser flops = 1.
- Reset asserted mid-frame aborts the frame immediately. No partial word is ever delivered.
- E = the cycle in which the IDLE edge condition is true (uart_rx falling edge + 2 cycles of synchroniser delay).
- Sample points, with N = DATA_BITS + (PARITY ≠ 0) + STOP_BITS and H = CLKS_PER_BIT/2:
  - start bit sampled at E + H
  - data bit i sampled at E + H + (i+1)·CLKS_PER_BIT
  - last stop bit sampled at E + H + N·CLKS_PER_BIT
- rx_valid rises on the clock after the last stop sample.
- busy is high from E+1 through the last stop sample cycle inclusive.
- rx_valid falls the cycle after an accepting handshake. Combinational rx_ready → rx_valid paths are forbidden.

## Test plan
- Basic 8N1 frame (CLKS_PER_BIT = 16, defaults), send 0xA5 → rx_valid rises at E + 8 + 9·16 + 1, rx_data = 0xA5, both error flags 0. Pulse rx_ready → rx_valid drops next cycle.
- Parity check (PARITY = 2, DATA_BITS = 7):
  - send 0x35 with correct even parity bit → parity_err = 0
  - resend with parity bit flipped → parity_err = 1, rx_data = 0x35
- Framing and break (STOP_BITS = 2):
  - second stop bit driven low → frame_err = 1, word still delivered
  - all-zero break frame → rx_data = 0, frame_err = 1
- Glitch and reset:
  - 3-cycle low pulse on an idle line → returns to IDLE, no rx_valid, busy drops
  - assert rst mid-DATA → all outputs at reset values; next clean frame 0x3C is received correctly
- Overrun and simultaneous events, with rx_ready held low:
  - send 0x11 then 0x22 → rx_data stays 0x11, overrun = 1; handshake clears overrun
  - assert rx_ready exactly on 0x33's completion cycle → rx_valid stays 1, rx_data = 0x33, no overrun
- Back-to-back frames (DATA_BITS = 9, 1 stop bit, no idle gap), send 0x1FF then 0x001 → both received in order, no errors.
